// File: rtl/switch_meta_bridge_if.sv
// Handshake bundle between the bridge and the switch ingress/egress logic.
// master = bridge side, slave = switch pipeline side.
interface switch_meta_bridge_if;
   logic        ing_valid;
   logic [31:0] ing_data;
   logic        ing_ready;
   logic        egr_valid;
   logic [31:0] egr_data;
   logic        egr_ready;

   modport master (
      output ing_valid, ing_data, egr_ready,
      input  ing_ready, egr_valid, egr_data
   );

   modport slave (
      input  ing_valid, ing_data, egr_ready,
      output ing_ready, egr_valid, egr_data
   );
endinterface

// File: rtl/switch_meta_bridge.sv
// Software metadata -> ingress FIFO, egress results -> readback FIFO.
// Define META_DROP_CNT_EN to build the saturating drop counter.
module switch_meta_bridge #(
   parameter int META_DEPTH = 8,
   parameter int EGR_DEPTH  = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 meta_en,
   input  logic [31:0]          meta_in,
   input  logic [31:0]          ctrl,
   input  logic                 rd_pop,
   switch_meta_bridge_if.master bus,
   output logic [31:0]          data_from_egress,
   output logic                 done,
   output logic [15:0]          drop_cnt
);

   localparam int MAW = $clog2(META_DEPTH);
   localparam int EAW = $clog2(EGR_DEPTH);
   localparam logic [MAW:0] MFULL = (MAW+1)'(META_DEPTH);
   localparam logic [EAW:0] EFULL = (EAW+1)'(EGR_DEPTH);

   logic en;
   logic flush;
   logic unused_ctrl;

   assign en          = ctrl[0];
   assign flush       = ctrl[1];
   assign unused_ctrl = ^ctrl[31:2];

   logic [31:0]    mmem [META_DEPTH];
   logic [MAW-1:0] mwr;
   logic [MAW-1:0] mrd;
   logic [MAW:0]   mcnt;
   logic           mfull;
   logic           mempty;
   logic           mpush;
   logic           mpop;

   assign mfull         = (mcnt == MFULL);
   assign mempty        = (mcnt == '0);
   assign bus.ing_valid = en & ~mempty;
   assign bus.ing_data  = bus.ing_valid ? mmem[mrd] : '0;
   assign mpop          = bus.ing_valid & bus.ing_ready;
   assign mpush         = meta_en & (~mfull | mpop);

   // Ingress pointers and occupancy; flush and reset drop everything.
   always_ff @(posedge clk) begin
      if (reset | flush) begin
         mwr  <= '0;
         mrd  <= '0;
         mcnt <= '0;
      end else begin
         if (mpush) mwr <= mwr + MAW'(1);
         if (mpop)  mrd <= mrd + MAW'(1);
         case ({mpush, mpop})
            2'b10:   mcnt <= mcnt + (MAW+1)'(1);
            2'b01:   mcnt <= mcnt - (MAW+1)'(1);
            default: mcnt <= mcnt;
         endcase
      end
   end

   // Ingress storage; contents need no reset since pointers gate reads.
   always_ff @(posedge clk) begin
      if (mpush & ~flush & ~reset) mmem[mwr] <= meta_in;
   end

   logic [31:0]    emem [EGR_DEPTH];
   logic [EAW-1:0] ewr;
   logic [EAW-1:0] erd;
   logic [EAW:0]   ecnt;
   logic           epush;
   logic           epop;

   assign done             = (ecnt != '0);
   assign data_from_egress = done ? emem[erd] : '0;
   assign bus.egr_ready    = en & (ecnt != EFULL);
   assign epush            = bus.egr_valid & bus.egr_ready;
   assign epop             = rd_pop & done;

   // Egress pointers and occupancy; pops on empty are ignored.
   always_ff @(posedge clk) begin
      if (reset | flush) begin
         ewr  <= '0;
         erd  <= '0;
         ecnt <= '0;
      end else begin
         if (epush) ewr <= ewr + EAW'(1);
         if (epop)  erd <= erd + EAW'(1);
         case ({epush, epop})
            2'b10:   ecnt <= ecnt + (EAW+1)'(1);
            2'b01:   ecnt <= ecnt - (EAW+1)'(1);
            default: ecnt <= ecnt;
         endcase
      end
   end

   // Egress storage write.
   always_ff @(posedge clk) begin
      if (epush & ~flush & ~reset) emem[ewr] <= bus.egr_data;
   end

`ifdef META_DROP_CNT_EN
   logic [15:0] drops;

   // Count words refused while the ingress FIFO is full; saturates.
   always_ff @(posedge clk) begin
      if (reset | flush) begin
         drops <= '0;
      end else if (meta_en & ~mpush & (drops != 16'hFFFF)) begin
         drops <= drops + 16'd1;
      end
   end

   assign drop_cnt = drops;
`else
   assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_switch_meta_bridge.sv
// Directed bench with a queue scoreboard for both FIFOs.
// Every cycle compares all outputs against the queue model.
module tb_switch_meta_bridge;

   logic        clk = 1'b0;
   logic        reset;
   logic        meta_en;
   logic [31:0] meta_in;
   logic [31:0] ctrl;
   logic        rd_pop;
   logic [31:0] data_from_egress;
   logic        done;
   logic [15:0] drop_cnt;

   switch_meta_bridge_if bus ();

   switch_meta_bridge #(
      .META_DEPTH (8),
      .EGR_DEPTH  (8)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .meta_en          (meta_en),
      .meta_in          (meta_in),
      .ctrl             (ctrl),
      .rd_pop           (rd_pop),
      .bus              (bus.master),
      .data_from_egress (data_from_egress),
      .done             (done),
      .drop_cnt         (drop_cnt)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [31:0] ing_q [$];
   logic [31:0] egr_q [$];
   int          drops = 0;
   int          cyc_n = 0;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s cyc %0d: got %h expected %h", tag, cyc_n, got, exp);
      end
   endtask

   // Check outputs mid-cycle, update the model, then advance one edge.
   task automatic cyc();
      logic        exp_iv;
      logic        exp_er;
      logic        ipop;
      logic [15:0] exp_dc;
      #4;
      exp_iv = ctrl[0] && (ing_q.size() > 0);
      exp_er = ctrl[0] && (egr_q.size() < 8);
      chk("ing_valid", {31'd0, bus.ing_valid}, {31'd0, exp_iv});
      chk("ing_data", bus.ing_data, exp_iv ? ing_q[0] : 32'd0);
      chk("egr_ready", {31'd0, bus.egr_ready}, {31'd0, exp_er});
      chk("done", {31'd0, done}, {31'd0, egr_q.size() > 0});
      chk("data_from_egress", data_from_egress,
          (egr_q.size() > 0) ? egr_q[0] : 32'd0);
`ifdef META_DROP_CNT_EN
      exp_dc = 16'(drops);
`else
      exp_dc = 16'd0;
`endif
      chk("drop_cnt", {16'd0, drop_cnt}, {16'd0, exp_dc});
      if (reset || ctrl[1]) begin
         ing_q.delete();
         egr_q.delete();
         drops = 0;
      end else begin
         ipop = exp_iv && bus.ing_ready;
         if (meta_en && ing_q.size() == 8 && !ipop) begin
            if (drops < 65535) drops++;
         end
         if (ipop) void'(ing_q.pop_front());
         if (meta_en && (ing_q.size() < 8)) ing_q.push_back(meta_in);
         if (rd_pop && egr_q.size() > 0) void'(egr_q.pop_front());
         if (bus.egr_valid && exp_er) egr_q.push_back(bus.egr_data);
      end
      @(posedge clk);
      #1;
      cyc_n++;
   endtask

   initial begin
      reset         = 1'b1;
      meta_en       = 1'b0;
      meta_in       = '0;
      ctrl          = '0;
      rd_pop        = 1'b0;
      bus.ing_ready = 1'b0;
      bus.egr_valid = 1'b0;
      bus.egr_data  = '0;
      @(posedge clk);
      #1;
      cyc();
      reset = 1'b0;
      cyc();

      // single word, one-cycle latency
      ctrl          = 32'h1;
      bus.ing_ready = 1'b1;
      meta_en       = 1'b1;
      meta_in       = 32'hA5A5_0001;
      cyc();
      meta_en = 1'b0;
      cyc();
      cyc();

      // overfill ingress, then drain in order
      bus.ing_ready = 1'b0;
      for (int i = 1; i <= 9; i++) begin
         meta_en = 1'b1;
         meta_in = 32'(i);
         cyc();
      end
      meta_en = 1'b0;
      cyc();
      bus.ing_ready = 1'b1;
      repeat (9) cyc();
      bus.ing_ready = 1'b0;

      // egress push and software pops, including pop on empty
      bus.egr_valid = 1'b1;
      bus.egr_data  = 32'hDEAD_BEEF;
      cyc();
      bus.egr_data = 32'h0000_0002;
      cyc();
      bus.egr_valid = 1'b0;
      rd_pop        = 1'b1;
      cyc();
      cyc();
      cyc();
      rd_pop = 1'b0;
      cyc();

      // fill egress, pop while offering 0x99
      bus.egr_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         bus.egr_data = 32'h10 + 32'(i);
         cyc();
      end
      bus.egr_data = 32'h99;
      rd_pop       = 1'b1;
      cyc();
      rd_pop = 1'b0;
      cyc();
      bus.egr_valid = 1'b0;
      rd_pop        = 1'b1;
      repeat (9) cyc();
      rd_pop = 1'b0;

      // simultaneous egress push and pop
      bus.egr_valid = 1'b1;
      bus.egr_data  = 32'h55;
      cyc();
      bus.egr_data = 32'h66;
      rd_pop       = 1'b1;
      cyc();
      bus.egr_valid = 1'b0;
      cyc();
      rd_pop = 1'b0;
      cyc();

      // flush with 3 words in each FIFO and a push in the flush cycle
      for (int i = 0; i < 3; i++) begin
         meta_en       = 1'b1;
         meta_in       = 32'hC000_0000 + 32'(i);
         bus.egr_valid = 1'b1;
         bus.egr_data  = 32'hE000_0000 + 32'(i);
         cyc();
      end
      bus.egr_valid = 1'b0;
      meta_in       = 32'hF1F1_F1F1;
      ctrl          = 32'h3;
      cyc();
      meta_en = 1'b0;
      ctrl    = 32'h1;
      cyc();
      cyc();

      // reset mid-operation with pushes in the reset cycle
      for (int i = 0; i < 2; i++) begin
         meta_en       = 1'b1;
         meta_in       = 32'hB000_0000 + 32'(i);
         bus.egr_valid = 1'b1;
         bus.egr_data  = 32'hD000_0000 + 32'(i);
         cyc();
      end
      meta_in      = 32'hBAD0_0001;
      bus.egr_data = 32'hBAD0_0002;
      reset        = 1'b1;
      cyc();
      reset         = 1'b0;
      meta_en       = 1'b0;
      bus.egr_valid = 1'b0;
      bus.ing_ready = 1'b1;
      rd_pop        = 1'b1;
      cyc();
      cyc();
      rd_pop        = 1'b0;
      bus.ing_ready = 1'b0;

      // enable dropped mid-stream: words held, rd_pop still works
      for (int i = 0; i < 2; i++) begin
         meta_en       = 1'b1;
         meta_in       = 32'h7000_0000 + 32'(i);
         bus.egr_valid = 1'b1;
         bus.egr_data  = 32'h8000_0000 + 32'(i);
         cyc();
      end
      meta_en       = 1'b0;
      ctrl          = 32'h0;
      bus.ing_ready = 1'b1;
      bus.egr_data  = 32'h8000_00FF;
      cyc();
      cyc();
      bus.egr_valid = 1'b0;
      rd_pop        = 1'b1;
      cyc();
      rd_pop = 1'b0;
      ctrl   = 32'h1;
      repeat (4) cyc();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
